timing_gen: RTL and testbench
=============================

// Module: timing_gen
// PURPOSE
//  Machine-cycle timing generator for the MCS-51 control unit. Produces S-state
//  (S1..S6), Phase (P1/P2) and cycles-remaining, which drive the address/enable
//  decoder one stage downstream. Sequences 12 clocks per machine cycle and
//  1/2/4 machine cycles per instruction, using the opcode currently in IR.
// PARAMETERS
//  HALT_EN   1   1: honour halt_req (PCON idle); 0: halt_req ignored
// PORTS
//  clk         in   1  core clock; all state changes on rising edge
//  rst_n       in   1  synchronous, active-low reset
//  IR          in   8  current opcode; stable from S1P1 of an instruction's first cycle
//  halt_req    in   1  request to freeze at the next instruction boundary
//  S           out  3  S-state: S1=001 S2=011 S3=010 S4=000 S5=100 S6=101
//  Phase       out  1  0=P1, 1=P2
//  cycles      out  2  11=first-cycle decode slot (S1 only); else machine cycles left
//  mc_start    out  1  high during S1P1 of every machine cycle
//  inst_end    out  1  high during S6P2 when cycles==00 (IR loads this clock)
//  halted      out  1  high while frozen
// BEHAVIOUR
//  - Reset (rst_n==0 at edge): S=S6, Phase=0, cycles=00, stretch=0, halted=0.
//    The first instruction's opcode is therefore fetched at S6 (IR loads at S6P2)
//    and decode starts at the following S1.
//  - Phase toggles every clock; S advances S1>S2>..>S6>S1 on the P2->P1 edge.
//    Illegal S codes (110,111) go to S1, Phase=0 on the next edge.
//  - Cycle counter (all updates on P2->P1 edges only):
//    * S6P2, cycles==00, not halting: next S1 gets cycles=11.
//    * S1P2, cycles==11: load N-1 from the cycle table for IR: 1-cycle->00,
//      2-cycle->01, 4-cycle->10 with stretch=1.
//    * S6P2, cycles!=00 and !=11: if cycles==10 && stretch, clear stretch
//      (cycles stays 10, giving the 4th cycle); else cycles-=1.
//  - Cycle table (standard MCS-51 timing): 4-cycle = 84h DIV, A4h MUL.
//    2-cycle = all jumps/calls/returns (x1h/x11h AJMP/ACALL, 02,12,22,32,73,80),
//    conditional branches (10,20,30,40,50,60,70,B4-BF,D5,D8-DF), MOVC 83,93,
//    MOVX E0,E2,E3,F0,F2,F3, PUSH C0, POP D0, 43,53,63,72,75,82,85-8F,90,92,
//    A0,A3,A6-A7,A8-AF,B0. Everything else is 1-cycle.
//  - Halt: if halt_req && HALT_EN at S6P2 with cycles==00, next state is S1P1,
//    cycles=11, halted=1; state then freezes. Release: halt_req low -> resumes
//    next edge from S1P1. halt_req is ignored mid-instruction.
//  - Outputs are registered state (mc_start, inst_end decoded combinationally
//    from S/Phase/cycles); latency 0 from state. A reset mid-instruction
//    aborts it and restarts at S6P1 with cycles=00.
//  - IR changing outside the S1P2 load point has no effect on the count.
// STRUCTURE
//  - Shared include timing_defs.vh: S1..S6 codes, CYC_DECODE=2'b11, Phase names;
//    the downstream decoder uses the same include.
//  - Sub-module inst_cycles_rom: combinational IR[7:0] -> {is4,is2}.
//  - Top: S/Phase sequencer, cycle counter + stretch bit, halt control.
// TESTING
//  1 Reset, hold 1 clk, release: S=101 Ph=0 cyc=00; 2 clks later S=001 Ph=0
//    cyc=11, mc_start=1.
//  2 IR=74h (MOV A,#): cyc 11 at S1, 00 from S2P1; inst_end at S6P2; 12 clks
//    per instruction; next S1 shows cyc=11.
//  3 IR=80h (SJMP): cyc 11 -> 01 after S1P2; 01 -> 00 at 2nd-cycle S1;
//    inst_end only in 2nd cycle; 24 clks total.
//  4 IR=A4h (MUL): cyc 11, 10, 10, 01, 00 across 4 machine cycles; 48 clks;
//    exactly one inst_end.
//  5 halt_req=1 during a 2-cycle instruction: no freeze until its S6P2; then
//    halted=1 at S1P1 cyc=11 for 20 clks; drop halt_req -> S1P2 next clk.
//  6 rst_n=0 at S4P2 of MUL 2nd cycle -> next clk S=101 Ph=0 cyc=00 stretch=0.

Source files
------------

// File: rtl/timing_gen_pkg.sv
// Shared timing definitions for the MCS-51 machine-cycle generator and the
// downstream address/enable decoder.
//   s_state_t  : S-state codes S1..S6 (Gray-like sequence)
//   phase_t    : P1/P2 phase names
//   CYC_DECODE : cycles value marking the first-cycle decode slot
//   next_s()   : S-state successor (illegal codes recover to S1)
package timing_gen_pkg;

    typedef enum logic [2:0] {
        S1 = 3'b001,
        S2 = 3'b011,
        S3 = 3'b010,
        S4 = 3'b000,
        S5 = 3'b100,
        S6 = 3'b101
    } s_state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } phase_t;

    localparam logic [1:0] CYC_DECODE = 2'b11;

    function automatic s_state_t next_s(input s_state_t s);
        case (s)
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            S4:      return S5;
            S5:      return S6;
            default: return S1;
        endcase
    endfunction

endpackage

// File: rtl/timing_gen_inst_cycles_rom.sv
// Opcode -> machine-cycle class lookup (standard MCS-51 timing).
//   IR  in  8  opcode
//   is4 out 1  4-cycle instruction (DIV, MUL)
//   is2 out 1  2-cycle instruction
// Neither set means a 1-cycle instruction.
module inst_cycles_rom (
    input  logic [7:0] IR,
    output logic       is4,
    output logic       is2
);

    always_comb begin
        is4 = (IR == 8'h84) || (IR == 8'hA4);
        is2 = 1'b0;
        // AJMP/ACALL occupy every x1h opcode
        if (IR[3:0] == 4'h1) begin
            is2 = 1'b1;
        end
        case (IR) inside
            8'h02, 8'h12, 8'h22, 8'h32, 8'h73, 8'h80,
            8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
            [8'hB4:8'hBF], 8'hD5, [8'hD8:8'hDF],
            8'h83, 8'h93,
            8'hE0, 8'hE2, 8'hE3, 8'hF0, 8'hF2, 8'hF3,
            8'hC0, 8'hD0,
            8'h43, 8'h53, 8'h63, 8'h72, 8'h75, 8'h82,
            [8'h85:8'h8F], 8'h90, 8'h92,
            8'hA0, 8'hA3, [8'hA6:8'hAF], 8'hB0: is2 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/timing_gen.sv
// MCS-51 machine-cycle timing generator.
//   clk      in   core clock
//   rst_n    in   synchronous active-low reset
//   IR       in   current opcode, sampled at S1P2 of the first cycle
//   halt_req in   freeze at the next instruction boundary
//   S        out  S-state code (S1..S6)
//   Phase    out  0=P1, 1=P2
//   cycles   out  11 = decode slot, else machine cycles remaining
//   mc_start out  S1P1 of every machine cycle
//   inst_end out  S6P2 of the last machine cycle
//   halted   out  frozen at S1P1 awaiting halt_req release
module timing_gen
    import timing_gen_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] IR,
    input  logic       halt_req,
    output logic [2:0] S,
    output logic       Phase,
    output logic [1:0] cycles,
    output logic       mc_start,
    output logic       inst_end,
    output logic       halted
);

    s_state_t   s_q, s_nxt;
    phase_t     ph_q, ph_nxt;
    logic [1:0] cyc_q, cyc_nxt;
    logic       str_q, str_nxt;
    logic       hlt_q, hlt_nxt;
    logic       is4, is2;
    logic       halt_ok;

    inst_cycles_rom u_rom (
        .IR  (IR),
        .is4 (is4),
        .is2 (is2)
    );

    assign halt_ok = halt_req && HALT_EN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q   <= S6;
            ph_q  <= P1;
            cyc_q <= 2'b00;
            str_q <= 1'b0;
            hlt_q <= 1'b0;
        end else begin
            s_q   <= s_nxt;
            ph_q  <= ph_nxt;
            cyc_q <= cyc_nxt;
            str_q <= str_nxt;
            hlt_q <= hlt_nxt;
        end
    end

    always_comb begin
        s_nxt   = s_q;
        ph_nxt  = ph_q;
        cyc_nxt = cyc_q;
        str_nxt = str_q;
        hlt_nxt = hlt_q;
        if (hlt_q) begin
            // Frozen at S1P1; release continues as a normal P1->P2 step
            if (!halt_ok) begin
                hlt_nxt = 1'b0;
                ph_nxt  = P2;
            end
        end else if (!(s_q inside {S1, S2, S3, S4, S5, S6})) begin
            s_nxt  = S1;
            ph_nxt = P1;
        end else if (ph_q == P1) begin
            ph_nxt = P2;
        end else begin
            ph_nxt = P1;
            s_nxt  = next_s(s_q);
            if (s_q == S6) begin
                if (cyc_q == 2'b00) begin
                    cyc_nxt = CYC_DECODE;
                    hlt_nxt = halt_ok;
                end else if (cyc_q != CYC_DECODE) begin
                    // Stretch holds 10 for one extra cycle to make four
                    if (cyc_q == 2'b10 && str_q) begin
                        str_nxt = 1'b0;
                    end else begin
                        cyc_nxt = cyc_q - 2'b01;
                    end
                end
            end else if (s_q == S1 && cyc_q == CYC_DECODE) begin
                if (is4) begin
                    cyc_nxt = 2'b10;
                    str_nxt = 1'b1;
                end else if (is2) begin
                    cyc_nxt = 2'b01;
                end else begin
                    cyc_nxt = 2'b00;
                end
            end
        end
    end

    assign S        = s_q;
    assign Phase    = ph_q;
    assign cycles   = cyc_q;
    assign halted   = hlt_q;
    assign mc_start = (s_q == S1) && (ph_q == P1);
    assign inst_end = (s_q == S6) && (ph_q == P2) && (cyc_q == 2'b00);

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen: a position-in-instruction reference
// model predicts the outputs after each clock and queues them; the outputs
// are popped and compared 1 ns after the rising edge.
module tb_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] IR = 8'h00;
    logic       halt_req = 1'b0;
    logic [2:0] S;
    logic       Phase;
    logic [1:0] cycles;
    logic       mc_start, inst_end, halted;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct packed {
        logic [2:0] s;
        logic       ph;
        logic [1:0] cyc;
        logic       mcs;
        logic       ie;
        logic       hl;
    } exp_t;

    exp_t q[$];

    // Reference model: clock position within the current instruction,
    // its length in machine cycles, and the halt flag.
    int unsigned m_pos = 10;
    int unsigned m_n = 1;
    bit          m_halt = 1'b0;

    timing_gen #(.HALT_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IR       (IR),
        .halt_req (halt_req),
        .S        (S),
        .Phase    (Phase),
        .cycles   (cycles),
        .mc_start (mc_start),
        .inst_end (inst_end),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run time exceeded (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned ref_cycles(input logic [7:0] op);
        if (op == 8'h84 || op == 8'hA4) return 4;
        if (op[3:0] == 4'h1) return 2;
        if ((op >= 8'hB4 && op <= 8'hBF) || (op >= 8'hD8 && op <= 8'hDF) ||
            (op >= 8'h85 && op <= 8'h8F) || (op >= 8'hA6 && op <= 8'hAF)) return 2;
        case (op)
            8'h02, 8'h12, 8'h22, 8'h32, 8'h73, 8'h80, 8'h10, 8'h20, 8'h30,
            8'h40, 8'h50, 8'h60, 8'h70, 8'hD5, 8'h83, 8'h93, 8'hE0, 8'hE2,
            8'hE3, 8'hF0, 8'hF2, 8'hF3, 8'hC0, 8'hD0, 8'h43, 8'h53, 8'h63,
            8'h72, 8'h75, 8'h82, 8'h90, 8'h92, 8'hA0, 8'hA3, 8'hB0: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int unsigned mc, t;
        logic [2:0] codes [6] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b100, 3'b101};
        mc = m_pos / 12;
        t  = m_pos % 12;
        e.s  = codes[t / 2];
        e.ph = (t % 2) == 1;
        if (mc == 0 && t < 2)  e.cyc = 2'b11;
        else if (m_n == 4)     e.cyc = (mc < 2) ? 2'b10 : (mc == 2) ? 2'b01 : 2'b00;
        else                   e.cyc = 2'(m_n - 1 - mc);
        e.mcs = (t == 0);
        e.ie  = (m_pos == 12 * m_n - 1);
        e.hl  = m_halt;
        return e;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_pos = 10; m_n = 1; m_halt = 1'b0;
        end else if (m_halt) begin
            if (!halt_req) begin
                m_halt = 1'b0; m_pos = 1;
            end
        end else if (m_pos == 1) begin
            m_n = ref_cycles(IR); m_pos = 2;
        end else if (m_pos == 12 * m_n - 1) begin
            m_pos = 0; m_halt = halt_req;
        end else begin
            m_pos++;
        end
    endtask

    // Called away from the clock edge; inputs are already set by the caller.
    task automatic tick();
        exp_t e;
        model_step();
        q.push_back(predict());
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("S", S, e.s);
        check("Phase", Phase, e.ph);
        check("cycles", cycles, e.cyc);
        check("mc_start", mc_start, e.mcs);
        check("inst_end", inst_end, e.ie);
        check("halted", halted, e.hl);
    endtask

    // Runs one instruction from S1P1 back to the next S1P1 (or halt).
    task automatic run_inst(input logic [7:0] op, input logic hreq);
        int unsigned clks = 0;
        int unsigned ends = 0;
        int unsigned n;
        n = ref_cycles(op);
        IR = op;
        halt_req = hreq;
        do begin
            tick();
            clks++;
            if (inst_end) ends++;
            if (m_pos >= 2) IR = 8'($urandom);
        end while (m_pos != 0 && clks < 60);
        check("inst_clks", clks, 12 * n);
        check("inst_end_count", ends, 1);
    endtask

    initial begin
        int unsigned guard;
        #2;
        // Reset and boot into the first decode slot
        rst_n = 1'b0;
        tick();
        check("rst_S", S, 3'b101);
        check("rst_cycles", cycles, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("boot_S", S, 3'b001);
        check("boot_cycles", cycles, 3);
        check("boot_mc_start", mc_start, 1);

        run_inst(8'h74, 1'b0);
        run_inst(8'h80, 1'b0);
        run_inst(8'hA4, 1'b0);
        run_inst(8'h84, 1'b0);
        run_inst(8'h11, 1'b0);
        run_inst(8'hE0, 1'b0);
        run_inst(8'h00, 1'b0);

        // Halt requested throughout a 2-cycle instruction
        run_inst(8'h80, 1'b1);
        check("halt_entered", halted, 1);
        repeat (20) tick();
        halt_req = 1'b0;
        IR = 8'h74;
        tick();
        check("release_S", S, 3'b001);
        check("release_Phase", Phase, 1);
        check("release_halted", halted, 0);
        guard = 0;
        while (m_pos != 0 && guard < 60) begin
            tick();
            guard++;
        end
        check("release_done", m_pos, 0);

        // Reset at S4P2 of the MUL second cycle
        IR = 8'hA4;
        guard = 0;
        while (m_pos != 19 && guard < 60) begin
            tick();
            guard++;
        end
        check("reach_S4P2", m_pos, 19);
        rst_n = 1'b0;
        tick();
        check("abort_S", S, 3'b101);
        check("abort_Phase", Phase, 0);
        check("abort_cycles", cycles, 0);
        rst_n = 1'b1;
        tick();
        tick();
        run_inst(8'hA4, 1'b0);

        repeat (24) run_inst(8'($urandom_range(0, 255)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
